// File: rtl/usb_stream_rx_if.sv
// rtl/usb_stream_rx_if.sv - FX2 slave-FIFO pad signals and consumer valid/ready stream for usb_stream_rx
interface usb_stream_rx_if;
  logic [1:0]  USB_STREAM_FIFOADDR;
  logic        USB_STREAM_SLOE_n;
  logic        USB_STREAM_SLRD_n;
  logic [2:0]  USB_STREAM_FLAGS_N;
  logic        USB_STREAM_FX2RDY;
  logic [15:0] USB_STREAM_DATA_IN;
  logic [15:0] DATA_OUT;
  logic        DATA_VALID;
  logic        DATA_READY;

  modport master (
    output USB_STREAM_FIFOADDR,
    output USB_STREAM_SLOE_n,
    output USB_STREAM_SLRD_n,
    input  USB_STREAM_FLAGS_N,
    input  USB_STREAM_FX2RDY,
    input  USB_STREAM_DATA_IN,
    output DATA_OUT,
    output DATA_VALID,
    input  DATA_READY
  );

  modport slave (
    input  USB_STREAM_FIFOADDR,
    input  USB_STREAM_SLOE_n,
    input  USB_STREAM_SLRD_n,
    output USB_STREAM_FLAGS_N,
    output USB_STREAM_FX2RDY,
    output USB_STREAM_DATA_IN,
    input  DATA_OUT,
    input  DATA_VALID,
    output DATA_READY
  );
endinterface

// File: rtl/usb_stream_rx.sv
// rtl/usb_stream_rx.sv - FX2 slave-FIFO OUT-endpoint reader feeding a FWFT buffer and valid/ready stream
// Optional sequence checker is built when USB_RX_SEQ_CHECK_EN is defined.
module usb_stream_rx #(
  parameter logic [1:0] EP_ADDR = 2'b00,
  parameter int         DEPTH   = 8
) (
  input  logic            STREAM_CLK,
  input  logic            STREAM_RST_N,
  input  logic            ENABLE,
  usb_stream_rx_if.master stream,
  output logic [31:0]     WORD_CNT,
  output logic [15:0]     SEQ_ERR_CNT
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_READ = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   mem_d [DEPTH];
  logic [31:0]   word_cnt_q, word_cnt_d;

  logic data_avail;
  logic burst_go;
  logic push;
  logic pop;
  logic flags_unused;

  assign data_avail   = stream.USB_STREAM_FLAGS_N[0];
  assign flags_unused = ^stream.USB_STREAM_FLAGS_N[2:1];
  assign burst_go     = ENABLE & stream.USB_STREAM_FX2RDY & data_avail;

  // A full buffer blocks the strobe even if a pop lands in the same cycle.
  assign push = (state_q == ST_READ) & data_avail & (count_q != FULL_CNT);
  assign pop  = (count_q != '0) & stream.DATA_READY;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (burst_go) state_d = ST_ARM;
      ST_ARM:  state_d = ST_READ;
      ST_READ: begin
        if (!data_avail || !ENABLE || !stream.USB_STREAM_FX2RDY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = stream.USB_STREAM_DATA_IN;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (push) word_cnt_d = word_cnt_q + 32'd1;
  end

  always_ff @(posedge STREAM_CLK or negedge STREAM_RST_N) begin
    if (!STREAM_RST_N) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      word_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      word_cnt_q <= word_cnt_d;
      mem_q      <= mem_d;
    end
  end

  assign stream.USB_STREAM_FIFOADDR = EP_ADDR;
  assign stream.USB_STREAM_SLOE_n   = ~((state_q == ST_ARM) | (state_q == ST_READ));
  assign stream.USB_STREAM_SLRD_n   = ~push;
  assign stream.DATA_VALID          = (count_q != '0);
  assign stream.DATA_OUT            = (count_q != '0) ? mem_q[rd_ptr_q] : 16'h0000;
  assign WORD_CNT                   = word_cnt_q;

`ifdef USB_RX_SEQ_CHECK_EN
  logic        seeded_q, seeded_d;
  logic [15:0] expect_q, expect_d;
  logic [15:0] seq_err_q, seq_err_d;

  // First captured word only seeds the expectation; afterwards each word is expected to be previous + 1.
  always_comb begin
    seeded_d  = seeded_q;
    expect_d  = expect_q;
    seq_err_d = seq_err_q;
    if (push) begin
      seeded_d = 1'b1;
      expect_d = stream.USB_STREAM_DATA_IN + 16'd1;
      if (seeded_q && (stream.USB_STREAM_DATA_IN != expect_q) && (seq_err_q != 16'hFFFF)) begin
        seq_err_d = seq_err_q + 16'd1;
      end
    end
  end

  always_ff @(posedge STREAM_CLK or negedge STREAM_RST_N) begin
    if (!STREAM_RST_N) begin
      seeded_q  <= 1'b0;
      expect_q  <= '0;
      seq_err_q <= '0;
    end else begin
      seeded_q  <= seeded_d;
      expect_q  <= expect_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign SEQ_ERR_CNT = seq_err_q;
`else
  assign SEQ_ERR_CNT = 16'h0000;
`endif

endmodule

// File: tb/tb_usb_stream_rx.sv
// tb/tb_usb_stream_rx.sv - self-checking bench for usb_stream_rx with an FX2 FIFO model and stream scoreboard
module tb_usb_stream_rx;
  localparam int DEPTH = 8;
`ifdef USB_RX_SEQ_CHECK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  typedef struct {
    int          n_words;
    logic [15:0] first;
    int          ready_mode;
    int          stall_at;
    int          stall_len;
    int          exp_captures;
    logic [15:0] exp_last;
    int          exp_arms;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [31:0] word_cnt;
  logic [15:0] seq_err_cnt;

  usb_stream_rx_if sif ();

  usb_stream_rx #(.EP_ADDR(2'b00), .DEPTH(DEPTH)) dut (
    .STREAM_CLK   (clk),
    .STREAM_RST_N (rst_n),
    .ENABLE       (enable),
    .stream       (sif.master),
    .WORD_CNT     (word_cnt),
    .SEQ_ERR_CNT  (seq_err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [15:0] fx2_q[$];
  logic [15:0] exp_q[$];
  int          n_strobes, n_pops;
  int          ready_mode;
  int          stall_target, stall_len, stall_left;
  logic        prev_sloe_n;
  int          arm_events, win_strobes, win_sloe_low;
  logic [15:0] last_out;
  int unsigned exp_wc;
  logic        have_prev;
  logic [15:0] prev_w;
  int          exp_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int occupancy();
    return n_strobes - n_pops;
  endfunction

  task automatic clear_model();
    fx2_q.delete();
    exp_q.delete();
    n_strobes = 0; n_pops = 0; exp_wc = 0;
    have_prev = 1'b0; prev_w = '0; exp_err = 0;
    stall_target = 0; stall_left = 0; prev_sloe_n = 1'b1;
  endtask

  task automatic tick();
    logic took, popped;
    logic [15:0] w;
    @(negedge clk);
    case (ready_mode)
      0:       sif.DATA_READY = 1'b0;
      1:       sif.DATA_READY = 1'b1;
      default: sif.DATA_READY = 1'($urandom_range(0, 1));
    endcase
    sif.USB_STREAM_FLAGS_N = {2'b11, (fx2_q.size() != 0) && (stall_left == 0)};
    sif.USB_STREAM_DATA_IN = (fx2_q.size() != 0) ? fx2_q[0] : 16'hDEAD;
    #1;
    took   = rst_n && !sif.USB_STREAM_SLRD_n;
    popped = rst_n && sif.DATA_VALID && sif.DATA_READY;
    if (rst_n) begin
      check("valid_vs_occupancy", {31'b0, sif.DATA_VALID}, {31'b0, occupancy() != 0});
      if (took) begin
        check("strobe_while_flag", {31'b0, sif.USB_STREAM_FLAGS_N[0]}, 32'd1);
        check("strobe_with_room", {31'b0, occupancy() < DEPTH}, 32'd1);
        check("sloe_before_strobe", {31'b0, prev_sloe_n}, 32'd0);
      end
      if (popped) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_word: got 0x%0h expected no word", sif.DATA_OUT);
        end else begin
          check("data_out_order", {16'b0, sif.DATA_OUT}, {16'b0, exp_q.pop_front()});
        end
        last_out = sif.DATA_OUT;
      end
    end
    if (!sif.USB_STREAM_SLOE_n && prev_sloe_n) arm_events++;
    if (took) win_strobes++;
    if (!sif.USB_STREAM_SLOE_n) win_sloe_low++;
    prev_sloe_n = sif.USB_STREAM_SLOE_n;
    @(posedge clk);
    #1;
    if (took && fx2_q.size() != 0) begin
      w = fx2_q.pop_front();
      n_strobes++;
      exp_wc++;
      if (have_prev && (w != 16'(prev_w + 16'd1)) && exp_err < 65535) exp_err++;
      have_prev = 1'b1;
      prev_w = w;
    end
    if (popped) n_pops++;
    if (stall_target != 0 && n_strobes == stall_target) begin
      stall_left = stall_len;
      stall_target = 0;
    end else if (stall_left > 0) begin
      stall_left--;
    end
  endtask

  task automatic drain(input string name);
    int cycles;
    cycles = 0;
    while (!(fx2_q.size() == 0 && exp_q.size() == 0 && occupancy() == 0) && cycles < 3000) begin
      tick();
      cycles++;
    end
    check({name, "_drain_in_time"}, {31'b0, cycles < 3000}, 32'd1);
  endtask

  task automatic load(input logic [15:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      fx2_q.push_back(16'(first + 16'(i)));
      exp_q.push_back(16'(first + 16'(i)));
    end
  endtask

  task automatic wait_strobes(input string name, input int target);
    int cycles;
    cycles = 0;
    while (n_strobes < target && cycles < 200) begin
      tick();
      cycles++;
    end
    check({name, "_reached"}, {31'b0, n_strobes >= target}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int base;
    base = n_strobes;
    arm_events = 0;
    stall_left = 0;
    ready_mode = v.ready_mode;
    stall_len = v.stall_len;
    stall_target = (v.stall_at != 0) ? base + v.stall_at : 0;
    load(v.first, v.n_words);
    drain("vec");
    check("vec_captures", n_strobes - base, v.exp_captures);
    check("vec_last_word", {16'b0, last_out}, {16'b0, v.exp_last});
    check("vec_word_cnt", word_cnt, exp_wc);
    check("vec_seq_err", {16'b0, seq_err_cnt}, SEQ_EN ? exp_err : 0);
    if (v.exp_arms >= 0) check("vec_arm_count", arm_events, v.exp_arms);
  endtask

  vec_t vecs[8];

  initial begin
    int base, n;
    logic [15:0] seq_words[5];

    vecs[0] = '{5, 16'h0010, 1, 0, 0, 5, 16'h0014, 1};
    vecs[1] = '{6, 16'h0100, 1, 3, 4, 6, 16'h0105, 2};
    vecs[2] = '{1, 16'h7FFF, 1, 0, 0, 1, 16'h7FFF, 1};
    vecs[3] = '{8, 16'hFFFC, 1, 0, 0, 8, 16'h0003, 1};
    for (int i = 4; i < 8; i++) begin
      n = int'($urandom_range(1, 30));
      vecs[i].n_words      = n;
      vecs[i].first        = 16'($urandom);
      vecs[i].ready_mode   = 2;
      vecs[i].stall_at     = int'($urandom_range(0, n - 1));
      vecs[i].stall_len    = int'($urandom_range(1, 6));
      vecs[i].exp_captures = n;
      vecs[i].exp_last     = 16'(vecs[i].first + 16'(n - 1));
      vecs[i].exp_arms     = -1;
    end

    rst_n = 1'b0;
    enable = 1'b1;
    sif.USB_STREAM_FX2RDY = 1'b1;
    sif.USB_STREAM_FLAGS_N = 3'b111;
    sif.USB_STREAM_DATA_IN = 16'h0;
    sif.DATA_READY = 1'b0;
    ready_mode = 1;
    last_out = '0;
    arm_events = 0; win_strobes = 0; win_sloe_low = 0;
    clear_model();
    repeat (3) tick();
    check("rst_fifoaddr", {30'b0, sif.USB_STREAM_FIFOADDR}, 32'd0);
    check("rst_sloe_n", {31'b0, sif.USB_STREAM_SLOE_n}, 32'd1);
    check("rst_slrd_n", {31'b0, sif.USB_STREAM_SLRD_n}, 32'd1);
    check("rst_valid", {31'b0, sif.DATA_VALID}, 32'd0);
    check("rst_data_out", {16'b0, sif.DATA_OUT}, 32'd0);
    check("rst_word_cnt", word_cnt, 32'd0);
    check("rst_seq_err", {16'b0, seq_err_cnt}, 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Backpressure: exactly DEPTH captures while the consumer stalls.
    base = n_strobes;
    ready_mode = 0;
    load(16'h2000, 20);
    repeat (40) tick();
    check("bp_captures_held", n_strobes - base, DEPTH);
    check("bp_slrd_high", {31'b0, sif.USB_STREAM_SLRD_n}, 32'd1);
    check("bp_valid", {31'b0, sif.DATA_VALID}, 32'd1);
    ready_mode = 1;
    drain("bp");
    check("bp_captures_total", n_strobes - base, 20);
    check("bp_last_word", {16'b0, last_out}, 32'h2013);

    // Gating on FX2RDY and ENABLE with data waiting.
    base = n_strobes;
    load(16'h2500, 4);
    sif.USB_STREAM_FX2RDY = 1'b0;
    win_strobes = 0; win_sloe_low = 0;
    repeat (20) tick();
    check("gate_rdy_strobes", win_strobes, 0);
    check("gate_rdy_sloe", win_sloe_low, 0);
    sif.USB_STREAM_FX2RDY = 1'b1;
    enable = 1'b0;
    win_strobes = 0; win_sloe_low = 0;
    repeat (20) tick();
    check("gate_en_strobes", win_strobes, 0);
    check("gate_en_sloe", win_sloe_low, 0);
    enable = 1'b1;
    drain("gate");
    check("gate_captures", n_strobes - base, 4);

    // ENABLE dropped mid-burst: the edge in flight still captures, then the burst ends.
    base = n_strobes;
    ready_mode = 1;
    load(16'h3000, 10);
    wait_strobes("en_mid", base + 3);
    enable = 1'b0;
    repeat (15) tick();
    check("en_mid_captures", n_strobes - base, 4);
    check("en_mid_remaining", exp_q.size(), 6);
    enable = 1'b1;
    drain("en_mid");
    check("en_mid_total", n_strobes - base, 10);

    // Asynchronous reset with three words buffered.
    ready_mode = 0;
    load(16'h4000, 10);
    base = n_strobes;
    wait_strobes("rst_mid", base + 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_slrd_n", {31'b0, sif.USB_STREAM_SLRD_n}, 32'd1);
    check("rst_mid_sloe_n", {31'b0, sif.USB_STREAM_SLOE_n}, 32'd1);
    check("rst_mid_valid", {31'b0, sif.DATA_VALID}, 32'd0);
    check("rst_mid_word_cnt", word_cnt, 32'd0);
    clear_model();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("rst_mid_word_cnt_after", word_cnt, 32'd0);

    // Sequence check across the 16-bit wrap, with one deliberate jump.
    seq_words = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0005, 16'h0006};
    ready_mode = 1;
    for (int i = 0; i < 5; i++) begin
      fx2_q.push_back(seq_words[i]);
      exp_q.push_back(seq_words[i]);
    end
    drain("seq");
    check("seq_word_cnt", word_cnt, 32'd5);
    check("seq_err_cnt", {16'b0, seq_err_cnt}, SEQ_EN ? 32'd1 : 32'd0);
    check("seq_last_word", {16'b0, last_out}, 32'h0006);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
